signal_lamp_driver: RTL and testbench
=====================================

# signal_lamp_driver

- Consumer end of the vehicle control state outputs.
- Takes the registered turn-state and gear-state codes and drives the physical lamps:
  - left/right indicator flashing, with comfort flashes;
  - reverse lamp;
  - periodic reverse beeper;
  - one-hot dash gear indicator.
- Sits directly downstream of the vehicle controller, in the same clock domain.

## Interface
Parameters:
- BLINK_HALF, 4: cycles per indicator on-phase and per off-phase (≥1).
- MIN_FLASHES, 3: minimum completed flashes per indicator activation (≥1).
- BEEP_ON, 2: beeper high cycles per period (≥1).
- BEEP_OFF, 6: beeper low cycles per period (≥1).

Ports:
- clock  in  1  single system clock, rising edge.
- _resetN  in  1  asynchronous, active-low reset.
- _switch  in  1  ignition; low forces all outputs off, synchronously.
- _turnState  in  2  00 none, 01 left, 11 right; 10 is invalid and treated as none.
- _gearState  in  2  00 lock, 01 parking, 10 reverse, 11 forward.
- _leftLamp  out  1  left indicator lamp.
- _rightLamp  out  1  right indicator lamp.
- _reverseLamp  out  1  reverse lamp.
- _beeper  out  1  reverse warning beeper.
- _gearLamp  out  3  dash indicator: bit0 P, bit1 R, bit2 D; 000 in lock.

## Operation
- **Indicator FSM states:** IDLE, FLASH_ON, FLASH_OFF.
- **Registers:** latched side (L/R), phase counter (0..BLINK_HALF-1), flash counter saturating at MIN_FLASHES.
- **IDLE:** both lamps 0. A valid left/right request moves to FLASH_ON at the next edge; side is latched, both counters cleared.
- **FLASH_ON:** lamp of the latched side = 1 for BLINK_HALF cycles. Then go to FLASH_OFF and increment the flash counter.
- **FLASH_OFF:** both lamps 0 for BLINK_HALF cycles. At the end of the phase:
  - same-side request → FLASH_ON;
  - no request and flash counter < MIN_FLASHES → FLASH_ON (comfort flash);
  - otherwise → IDLE.
- **Request dropped to none during FLASH_ON/FLASH_OFF:** current phase runs to completion; the decision is made only at the end of FLASH_OFF.
- **Opposite-side request in FLASH_ON/FLASH_OFF:** preempts at the next edge. Old lamp off, new side latched, FLASH_ON entered, both counters cleared.
- **Reverse lamp:** _reverseLamp = 1 while _gearState == reverse and _switch = 1.
- **Beeper:** runs while the reverse lamp is on, starting with the on-phase:
  - BEEP_ON high, then BEEP_OFF low, repeating;
  - leaving reverse clears the beeper counter.
- **Gear indicator:** _gearLamp decodes _gearState; lock → 000.
- **_switch = 0:** at the next edge all outputs go to 0, the FSM goes to IDLE, and all counters clear. This has priority over every transition.
- **Counter widths:** $clog2 of the respective maximum, minimum 1 bit. Counters never wrap past their terminal value.

## Timing
- All outputs are registered: 1-cycle latency from the input sample to the output.
- Async reset: all outputs 0, FSM IDLE, counters 0 immediately, without a clock edge. Reset deassertion is expected to be synchronised externally.
- **Flash cadence:** a request sampled at edge E0 drives the lamp high after E0 for BLINK_HALF cycles, then low for BLINK_HALF cycles. Flash period = 2·BLINK_HALF cycles.
- **Comfort sequence:** a 1-cycle request yields exactly MIN_FLASHES flashes, i.e. 2·BLINK_HALF·MIN_FLASHES cycles, then IDLE.
- **Beeper period:** BEEP_ON + BEEP_OFF cycles. The first high cycle coincides with the first _reverseLamp = 1 cycle.
- **Simultaneous events:**
  - _switch low beats everything.
  - A side change and a phase end in the same cycle → the side change wins.
  - A gear change and the end of a beeper phase in the same cycle → the gear change wins (beeper 0).

## Structure
- Shared package vehicle_pkg holds:
  - the turn encodings, shared with the vehicle controller;
  - the gear encodings, shared with the vehicle controller;
  - the indicator FSM enum;
  - the _gearLamp bit positions.
- Sub-module lamp_period_counter:
  - generic terminal-count counter with clear and enable;
  - outputs a done pulse at count = LIMIT-1;
  - instantiated for the indicator phase and the beeper phase.

## Test plan
All scenarios use default parameters.

1. Async reset mid-flash → all outputs 0 with no edge. After release, with _switch = 1 and parking → _gearLamp = 001 one cycle later.
2. Left for 1 cycle, then none → _leftLamp pattern 11110000 ×3 (24 cycles), then IDLE. _rightLamp = 0 throughout.
3. Left held; right applied at cycle 6 (in the off-phase) → next cycle _rightLamp = 1, _leftLamp = 0. Right then flashes a fresh 3-flash minimum.
4. Reverse for 16 cycles → _reverseLamp = 1 after 1 cycle, _beeper = 11000000 ×2. Then forward → _reverseLamp = 0, _beeper = 0, _gearLamp = 100 next cycle.
5. _switch dropped at cycle 2 of a left on-phase → all outputs 0 at the next edge. Re-asserting _switch with turn = none → no comfort flashes.
6. _turnState = 10 for 10 cycles from IDLE → no lamp activity.

Source files
------------

// File: rtl/vehicle_pkg.sv
// Encodings shared between the vehicle controller and the lamp driver,
// plus the indicator FSM state type and dash gear-lamp bit positions.
package vehicle_pkg;

  typedef enum logic [1:0] {
    TURN_NONE    = 2'b00,
    TURN_LEFT    = 2'b01,
    TURN_INVALID = 2'b10,
    TURN_RIGHT   = 2'b11
  } turn_e;

  typedef enum logic [1:0] {
    GEAR_LOCK    = 2'b00,
    GEAR_PARK    = 2'b01,
    GEAR_REVERSE = 2'b10,
    GEAR_FORWARD = 2'b11
  } gear_e;

  typedef enum logic [1:0] {
    IND_IDLE      = 2'd0,
    IND_FLASH_ON  = 2'd1,
    IND_FLASH_OFF = 2'd2
  } ind_state_e;

  typedef enum logic {
    SIDE_LEFT  = 1'b0,
    SIDE_RIGHT = 1'b1
  } side_e;

  localparam int GEAR_LAMP_P = 0;
  localparam int GEAR_LAMP_R = 1;
  localparam int GEAR_LAMP_D = 2;

  function automatic logic [2:0] gear_lamp_decode(input logic [1:0] gear);
    logic [2:0] lamp;
    lamp = '0;
    case (gear)
      GEAR_PARK:    lamp[GEAR_LAMP_P] = 1'b1;
      GEAR_REVERSE: lamp[GEAR_LAMP_R] = 1'b1;
      GEAR_FORWARD: lamp[GEAR_LAMP_D] = 1'b1;
      default:      lamp = '0;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/lamp_period_counter.sv
// Terminal-count phase counter: counts 0..LIMIT-1 while enabled, wraps to 0
// after the terminal value; done_o is high while the count sits at LIMIT-1.
module lamp_period_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clock,
  input  logic _resetN,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge _resetN) begin
    if (!_resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == LAST);

endmodule

// File: rtl/signal_lamp_driver.sv
// Drives indicator, reverse, beeper and dash gear lamps from the vehicle
// controller's turn/gear codes. Every output is a register.
module signal_lamp_driver
  import vehicle_pkg::*;
#(
  parameter int unsigned BLINK_HALF  = 4,
  parameter int unsigned MIN_FLASHES = 3,
  parameter int unsigned BEEP_ON     = 2,
  parameter int unsigned BEEP_OFF    = 6
) (
  input  logic       clock,
  input  logic       _resetN,
  input  logic       _switch,
  input  logic [1:0] _turnState,
  input  logic [1:0] _gearState,
  output logic       _leftLamp,
  output logic       _rightLamp,
  output logic       _reverseLamp,
  output logic       _beeper,
  output logic [2:0] _gearLamp
);

  localparam int unsigned FLASH_W = (MIN_FLASHES > 0) ? $clog2(MIN_FLASHES + 1) : 1;
  localparam logic [FLASH_W-1:0] FLASH_MAX = FLASH_W'(MIN_FLASHES);

  ind_state_e         state_q, state_d;
  side_e              side_q, side_d;
  logic [FLASH_W-1:0] flash_q, flash_d;

  logic  req_left, req_right, req_valid;
  side_e req_side;
  logic  preempt;
  logic  phase_done, phase_clr, phase_en;

  logic       left_d, right_d, rev_d, beep_d;
  logic [2:0] gear_d;
  logic       beep_clr, beep_on_done, beep_off_done;

  // Code 10 is deliberately not a request: it behaves exactly like none.
  assign req_left  = (_turnState == TURN_LEFT);
  assign req_right = (_turnState == TURN_RIGHT);
  assign req_valid = req_left || req_right;
  assign req_side  = req_right ? SIDE_RIGHT : SIDE_LEFT;
  assign preempt   = req_valid && (state_q != IND_IDLE) && (req_side != side_q);

  assign phase_clr = !_switch || (state_q == IND_IDLE) || preempt;
  assign phase_en  = (state_q != IND_IDLE);

  lamp_period_counter #(.LIMIT(BLINK_HALF)) u_phase_cnt (
    .clock   (clock),
    ._resetN (_resetN),
    .clr_i   (phase_clr),
    .en_i    (phase_en),
    .done_o  (phase_done)
  );

  // Beeper phases use the registered beeper output as the phase marker.
  assign beep_clr = !rev_d || !_reverseLamp;

  lamp_period_counter #(.LIMIT(BEEP_ON)) u_beep_on_cnt (
    .clock   (clock),
    ._resetN (_resetN),
    .clr_i   (beep_clr),
    .en_i    (_beeper),
    .done_o  (beep_on_done)
  );

  lamp_period_counter #(.LIMIT(BEEP_OFF)) u_beep_off_cnt (
    .clock   (clock),
    ._resetN (_resetN),
    .clr_i   (beep_clr),
    .en_i    (!_beeper),
    .done_o  (beep_off_done)
  );

  always_ff @(posedge clock or negedge _resetN) begin
    if (!_resetN) begin
      state_q      <= IND_IDLE;
      side_q       <= SIDE_LEFT;
      flash_q      <= '0;
      _leftLamp    <= 1'b0;
      _rightLamp   <= 1'b0;
      _reverseLamp <= 1'b0;
      _beeper      <= 1'b0;
      _gearLamp    <= '0;
    end else begin
      state_q      <= state_d;
      side_q       <= side_d;
      flash_q      <= flash_d;
      _leftLamp    <= left_d;
      _rightLamp   <= right_d;
      _reverseLamp <= rev_d;
      _beeper      <= beep_d;
      _gearLamp    <= gear_d;
    end
  end

  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    flash_d = flash_q;
    if (!_switch) begin
      state_d = IND_IDLE;
      flash_d = '0;
    end else begin
      case (state_q)
        IND_IDLE: begin
          flash_d = '0;
          if (req_valid) begin
            state_d = IND_FLASH_ON;
            side_d  = req_side;
          end
        end
        IND_FLASH_ON: begin
          if (preempt) begin
            side_d  = req_side;
            flash_d = '0;
          end else if (phase_done) begin
            state_d = IND_FLASH_OFF;
            if (flash_q != FLASH_MAX) flash_d = flash_q + 1'b1;
          end
        end
        IND_FLASH_OFF: begin
          if (preempt) begin
            state_d = IND_FLASH_ON;
            side_d  = req_side;
            flash_d = '0;
          end else if (phase_done) begin
            if ((req_valid && (req_side == side_q)) || (flash_q < FLASH_MAX)) begin
              state_d = IND_FLASH_ON;
            end else begin
              state_d = IND_IDLE;
            end
          end
        end
        default: state_d = IND_IDLE;
      endcase
    end
  end

  always_comb begin
    left_d  = (state_d == IND_FLASH_ON) && (side_d == SIDE_LEFT);
    right_d = (state_d == IND_FLASH_ON) && (side_d == SIDE_RIGHT);
    rev_d   = _switch && (_gearState == GEAR_REVERSE);
    gear_d  = _switch ? gear_lamp_decode(_gearState) : 3'b000;
    if (!rev_d) begin
      beep_d = 1'b0;
    end else if (!_reverseLamp) begin
      beep_d = 1'b1;
    end else if (_beeper) begin
      beep_d = !beep_on_done;
    end else begin
      beep_d = beep_off_done;
    end
  end

endmodule

// File: tb/tb_signal_lamp_driver.sv
// Directed and randomized bench for signal_lamp_driver; expected outputs come
// from a cycle-count model of the flash/beep timelines.
module tb_signal_lamp_driver;

  localparam int BH   = 4;
  localparam int MINF = 3;
  localparam int BON  = 2;
  localparam int BOFF = 6;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw    = 1'b0;
  logic [1:0] turn  = 2'b00;
  logic [1:0] gear  = 2'b00;
  logic       left, right, rev, beep;
  logic [2:0] glamp;

  int checks = 0;
  int errors = 0;

  // Model: position inside the current flash period and flashes completed.
  bit         m_active;
  int         m_side;
  int         m_p;
  int         m_k;
  int         m_rt;
  bit         e_left, e_right, e_rev, e_beep;
  logic [2:0] e_gear;

  always #5 clock = ~clock;

  signal_lamp_driver #(
    .BLINK_HALF (BH),
    .MIN_FLASHES(MINF),
    .BEEP_ON    (BON),
    .BEEP_OFF   (BOFF)
  ) dut (
    .clock       (clock),
    ._resetN     (rst_n),
    ._switch     (sw),
    ._turnState  (turn),
    ._gearState  (gear),
    ._leftLamp   (left),
    ._rightLamp  (right),
    ._reverseLamp(rev),
    ._beeper     (beep),
    ._gearLamp   (glamp)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_side = 0; m_p = 0; m_k = 0; m_rt = 0;
    e_left = 0; e_right = 0; e_rev = 0; e_beep = 0; e_gear = 3'b000;
  endtask

  task automatic model_edge(input logic s, input logic [1:0] t, input logic [1:0] g);
    int req;
    req = (t == 2'b01) ? 1 : (t == 2'b11) ? 2 : 0;
    if (!s) begin
      m_active = 0; m_p = 0; m_k = 0;
    end else if (m_active) begin
      if (req != 0 && req != m_side) begin
        m_side = req; m_p = 0; m_k = 0;
      end else begin
        m_p++;
        if (m_p == 2 * BH) begin
          m_k++;
          if (req == m_side || m_k < MINF) m_p = 0;
          else m_active = 0;
        end
      end
    end else if (req != 0) begin
      m_active = 1; m_side = req; m_p = 0; m_k = 0;
    end
    e_rev = s && (g == 2'b10);
    if (e_rev) begin
      e_beep = (m_rt % (BON + BOFF)) < BON;
      m_rt++;
    end else begin
      e_beep = 0;
      m_rt = 0;
    end
    e_left  = s && m_active && m_side == 1 && m_p < BH;
    e_right = s && m_active && m_side == 2 && m_p < BH;
    if (!s)              e_gear = 3'b000;
    else if (g == 2'b01) e_gear = 3'b001;
    else if (g == 2'b10) e_gear = 3'b010;
    else if (g == 2'b11) e_gear = 3'b100;
    else                 e_gear = 3'b000;
  endtask

  task automatic step(input logic s, input logic [1:0] t, input logic [1:0] g, input string tag);
    sw = s; turn = t; gear = g;
    @(posedge clock);
    model_edge(s, t, g);
    #1;
    chk({tag, ".left"},  int'(left),  int'(e_left));
    chk({tag, ".right"}, int'(right), int'(e_right));
    chk({tag, ".rev"},   int'(rev),   int'(e_rev));
    chk({tag, ".beep"},  int'(beep),  int'(e_beep));
    chk({tag, ".gear"},  int'(glamp), int'(e_gear));
  endtask

  initial begin
    int cnt;
    int hold;
    logic s_r;
    logic [1:0] t_r, g_r;

    model_reset();
    #12 rst_n = 1'b1;
    chk("reset.outs", int'({left, right, rev, beep, glamp}), 0);

    // Single-cycle left request: three comfort flashes, then idle
    step(1'b1, 2'b01, 2'b01, "t2.req");
    cnt = int'(left);
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 2'b00, 2'b01, "t2.run");
      cnt += int'(left);
    end
    chk("t2.left_on_cycles", cnt, BH * MINF);

    // Left held, right arrives in the off-phase and preempts
    for (int i = 0; i < 6; i++) step(1'b1, 2'b01, 2'b01, "t3.left");
    step(1'b1, 2'b11, 2'b01, "t3.pre");
    chk("t3.right_now", int'(right), 1);
    chk("t3.left_now", int'(left), 0);
    cnt = int'(right);
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 2'b00, 2'b01, "t3.run");
      cnt += int'(right);
    end
    chk("t3.right_on_cycles", cnt, BH * MINF);

    // Reverse for 16 cycles, then forward
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'b00, 2'b10, "t4.rev");
      cnt += int'(beep);
    end
    chk("t4.beep_cycles", cnt, 2 * BON);
    step(1'b1, 2'b00, 2'b11, "t4.fwd");
    chk("t4.gear_fwd", int'(glamp), 4);

    // Async reset mid-flash, away from any clock edge
    step(1'b1, 2'b01, 2'b01, "t1.req");
    step(1'b1, 2'b01, 2'b01, "t1.run");
    #2 rst_n = 1'b0;
    #1;
    chk("t1.async_outs", int'({left, right, rev, beep, glamp}), 0);
    model_reset();
    #10 rst_n = 1'b1;
    step(1'b1, 2'b00, 2'b01, "t1.park");
    chk("t1.gear_park", int'(glamp), 1);

    // Ignition drop in an on-phase, then no comfort flashes after return
    step(1'b1, 2'b01, 2'b01, "t5.req");
    step(1'b1, 2'b01, 2'b01, "t5.on");
    step(1'b0, 2'b01, 2'b01, "t5.off");
    chk("t5.all_off", int'({left, right, rev, beep, glamp}), 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 2'b00, 2'b01, "t5.idle");
      cnt += int'(left) + int'(right);
    end
    chk("t5.no_flash", cnt, 0);

    // Invalid turn code from idle
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'b10, 2'b01, "t6.inv");
      cnt += int'(left) + int'(right);
    end
    chk("t6.no_flash", cnt, 0);

    // Randomized segments of held inputs
    for (int seg = 0; seg < 80; seg++) begin
      hold = int'($urandom_range(1, 12));
      s_r  = ($urandom_range(0, 15) != 0);
      t_r  = 2'($urandom_range(0, 3));
      g_r  = ($urandom_range(0, 2) == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      for (int i = 0; i < hold; i++) step(s_r, t_r, g_r, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
